// File: rtl/vga_frame_scheduler.sv
// Pixel compositor and vblank-only round-robin update scheduler.
// Pixel path has one clock of latency; update grants open only in vblank.
module vga_frame_scheduler #(
    parameter int NREQ     = 4,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_TOTAL  = 800,
    parameter int V_TOTAL  = 525
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [15:0]          H_address,
    input  logic [15:0]          V_address,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      layer_on,
    input  logic [12*NREQ-1:0]   layer_rgb,
    input  logic [11:0]          bg_rgb,
    output logic [NREQ-1:0]      gnt,
    output logic                 preempt,
    output logic                 frame_tick,
    output logic [11:0]          rgb,
    output logic                 active
);
    localparam int IW = $clog2(NREQ);
    localparam logic [15:0] HA = 16'(H_ACTIVE);
    localparam logic [15:0] VA = 16'(V_ACTIVE);
    localparam logic [15:0] HL = 16'(H_TOTAL - 1);
    localparam logic [15:0] VL = 16'(V_TOTAL - 1);
    localparam logic [IW-1:0] LAST = IW'(NREQ - 1);

    typedef enum logic [1:0] {
        S_ACTIVE,
        S_PICK,
        S_GRANT,
        S_DONE
    } state_t;

    state_t          state;
    logic [IW-1:0]   rr;
    logic [IW-1:0]   g;
    logic [NREQ-1:0] served;

    logic vis;
    logic vb_start;
    logic vb_end;

    assign vis      = (H_address < HA) && (V_address < VA);
    assign vb_start = (H_address == 16'd0) && (V_address == VA);
    assign vb_end   = (H_address == HL) && (V_address == VL);

    logic [11:0] pix;
    logic        hit;

    always_comb begin
        pix = bg_rgb;
        hit = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!hit && layer_on[i]) begin
                pix = layer_rgb[12*i +: 12];
                hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb        <= 12'h000;
            active     <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            rgb        <= vis ? pix : 12'h000;
            active     <= vis;
            frame_tick <= vb_start;
        end
    end

    logic [NREQ-1:0] elig;
    logic            found;
    logic [IW-1:0]   pick;
    logic [IW-1:0]   g_inc;

    assign elig  = req & ~served;
    assign g_inc = (g == LAST) ? '0 : g + 1'b1;

    // Rotating search starting at rr, wrapping at NREQ.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = int'(rr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && elig[idx]) begin
                found = 1'b1;
                pick  = IW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_ACTIVE;
            gnt     <= '0;
            preempt <= 1'b0;
            rr      <= '0;
            g       <= '0;
            served  <= '0;
        end else begin
            preempt <= 1'b0;
            unique case (state)
                S_ACTIVE: begin
                    gnt <= '0;
                    if (vb_start) begin
                        served <= '0;
                        state  <= S_PICK;
                    end
                end
                S_PICK: begin
                    if (vb_end) begin
                        state <= S_ACTIVE;
                    end else if (found) begin
                        gnt   <= NREQ'(1) << pick;
                        g     <= pick;
                        state <= S_GRANT;
                    end else begin
                        state <= S_DONE;
                    end
                end
                S_GRANT: begin
                    // A release in the vb_end cycle wins over revocation.
                    if (!req[g]) begin
                        gnt       <= '0;
                        served[g] <= 1'b1;
                        rr        <= g_inc;
                        state     <= vb_end ? S_ACTIVE : S_PICK;
                    end else if (vb_end) begin
                        gnt     <= '0;
                        preempt <= 1'b1;
                        rr      <= g_inc;
                        state   <= S_ACTIVE;
                    end
                end
                S_DONE: begin
                    gnt <= '0;
                    if (vb_end) state <= S_ACTIVE;
                end
                default: state <= S_ACTIVE;
            endcase
        end
    end
endmodule
